// File: rtl/key_step_control_pkg.sv
// Shared encodings for the key/switch conditioner: mode codes, FSM states,
// key indices and small decode helpers.
package key_step_control_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_DIV  = 2'b10;

    localparam int KEY_RST   = 0;
    localparam int KEY_STEP  = 1;
    localparam int KEY_PAUSE = 2;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_DIV   = 2'd3
    } state_t;

    // The unused switch code 11 falls back to single-step, the safest mode.
    function automatic logic [1:0] decode_mode(input logic [1:0] sw);
        return (sw == 2'b11) ? MODE_STEP : sw;
    endfunction

    function automatic state_t mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_RUN: return S_RUN;
            MODE_DIV: return S_DIV;
            default:  return S_STEP;
        endcase
    endfunction

    function automatic logic [1:0] state_to_mode(input state_t st);
        case (st)
            S_RUN:   return MODE_RUN;
            S_DIV:   return MODE_DIV;
            default: return MODE_STEP;
        endcase
    endfunction

    function automatic logic [31:0] div_mask(input logic [4:0] e);
        return (32'd1 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/key_step_control_if.sv
// Board-side bundle of the conditioner: raw keys/switches in, CPU controls out.
// oStepCount exists only when KEYCTRL_STEP_COUNT_EN is defined.
interface key_step_control_if;
    import key_step_control_pkg::*;

    logic [3:0]  iKEY;
    logic [9:0]  iSW;
    logic        oCPU_RST;
    logic        oCLK_EN;
    logic [1:0]  oMode;
    logic        oPaused;
    logic [3:0]  oKeyDb;
    state_t      dbg_state;
`ifdef KEYCTRL_STEP_COUNT_EN
    logic [31:0] oStepCount;

    modport master (
        output iKEY, iSW,
        input  oCPU_RST, oCLK_EN, oMode, oPaused, oKeyDb, dbg_state, oStepCount
    );
    modport slave (
        input  iKEY, iSW,
        output oCPU_RST, oCLK_EN, oMode, oPaused, oKeyDb, dbg_state, oStepCount
    );
`else
    modport master (
        output iKEY, iSW,
        input  oCPU_RST, oCLK_EN, oMode, oPaused, oKeyDb, dbg_state
    );
    modport slave (
        input  iKEY, iSW,
        output oCPU_RST, oCLK_EN, oMode, oPaused, oKeyDb, dbg_state
    );
`endif
endinterface

// File: rtl/key_step_control_debounce.sv
// Single-key conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on each debounced press (1 -> 0).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 17
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iRaw,
    output logic oLevel,
    output logic oPress
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_flip;

    assign w_flip = (r_sync != r_stable) && (r_cnt == LAST);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta  <= iRaw;
            r_sync  <= r_meta;
            // Pulse only on the high-to-low flip; releases are silent.
            r_press <= w_flip && r_stable;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign oLevel = r_stable;
    assign oPress = r_press;

endmodule

// File: rtl/key_step_control.sv
// Turns debounced board keys and switches into a stretched CPU reset and a
// one-cycle CPU clock-enable. Define KEYCTRL_STEP_COUNT_EN to add oStepCount.
module key_step_control
    import key_step_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RESET_STRETCH   = 8,
    parameter int CNT_W           = 17
) (
    input  logic iCLK,
    input  logic iRST,
    key_step_control_if.slave bus
);

    localparam int STRETCH_W = (RESET_STRETCH < 1) ? 1 : $clog2(RESET_STRETCH + 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(RESET_STRETCH);

    logic [3:0] w_key_db;
    logic [3:0] w_press;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .iCLK  (iCLK),
            .iRST  (iRST),
            .iRaw  (bus.iKEY[gi]),
            .oLevel(w_key_db[gi]),
            .oPress(w_press[gi])
        );
    end

    logic [9:0] r_sw_meta;
    logic [9:0] r_sw_sync;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= bus.iSW;
            r_sw_sync <= r_sw_meta;
        end
    end

    logic [1:0] w_mode_req;
    logic [4:0] w_exp;
    logic       w_unused_bits;

    assign w_mode_req    = decode_mode(r_sw_sync[1:0]);
    assign w_exp         = r_sw_sync[6:2];
    assign w_unused_bits = ^{w_press[3], r_sw_sync[9:7]};

    state_t                r_state;
    logic [STRETCH_W-1:0]  r_stretch;
    logic [31:0]           r_div;
    logic                  r_paused;
    logic                  r_clk_en;
    logic                  r_cpu_rst;
    logic [1:0]            r_mode;
    logic [4:0]            r_exp_prev;

    state_t                w_state_nxt;
    logic [STRETCH_W-1:0]  w_stretch_nxt;
    logic [31:0]           w_div_nxt;
    logic                  w_paused_nxt;
    logic                  w_clk_en_nxt;
    logic [1:0]            w_mode_nxt;
    logic                  w_exp_changed;

    assign w_exp_changed = (w_exp != r_exp_prev);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state    <= S_RESET;
            r_stretch  <= STRETCH_LOAD;
            r_div      <= '0;
            r_paused   <= 1'b0;
            r_clk_en   <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_mode     <= MODE_RUN;
            r_exp_prev <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stretch  <= w_stretch_nxt;
            r_div      <= w_div_nxt;
            r_paused   <= w_paused_nxt;
            r_clk_en   <= w_clk_en_nxt;
            r_cpu_rst  <= (w_state_nxt == S_RESET);
            r_mode     <= w_mode_nxt;
            r_exp_prev <= w_exp;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stretch_nxt = r_stretch;
        w_div_nxt     = r_div;
        w_paused_nxt  = r_paused;
        w_clk_en_nxt  = 1'b0;
        w_mode_nxt    = r_mode;

        // A reset-key press overrides every other event in the same cycle.
        if (w_press[KEY_RST]) begin
            w_state_nxt   = S_RESET;
            w_stretch_nxt = STRETCH_LOAD;
            w_div_nxt     = '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (!w_key_db[KEY_RST]) begin
                        w_stretch_nxt = STRETCH_LOAD;
                    end else if (r_stretch != '0) begin
                        w_stretch_nxt = r_stretch - 1'b1;
                    end else begin
                        w_state_nxt = mode_to_state(w_mode_req);
                    end
                end
                default: begin
                    w_state_nxt = mode_to_state(w_mode_req);
                    if (w_press[KEY_PAUSE] && (r_state != S_STEP)) begin
                        w_paused_nxt = !r_paused;
                    end
                end
            endcase

            if ((w_state_nxt != r_state) || w_exp_changed || (r_state == S_RESET)) begin
                w_div_nxt = '0;
            end else if ((r_state == S_DIV) && !w_paused_nxt) begin
                if (r_div == div_mask(w_exp)) begin
                    w_div_nxt    = '0;
                    w_clk_en_nxt = 1'b1;
                end else begin
                    w_div_nxt = r_div + 32'd1;
                end
            end

            // Step presses count only when already settled in STEP.
            case (w_state_nxt)
                S_RUN:   w_clk_en_nxt = !w_paused_nxt;
                S_STEP:  w_clk_en_nxt = (r_state == S_STEP) && w_press[KEY_STEP];
                default: ;
            endcase
        end

        if (w_state_nxt != S_RESET) begin
            w_mode_nxt = state_to_mode(w_state_nxt);
        end
    end

`ifdef KEYCTRL_STEP_COUNT_EN
    logic [31:0] r_step_cnt;

    always_ff @(posedge iCLK) begin
        if (iRST || r_cpu_rst) begin
            r_step_cnt <= '0;
        end else if (r_clk_en) begin
            r_step_cnt <= r_step_cnt + 32'd1;
        end
    end

    assign bus.oStepCount = r_step_cnt;
`endif

    assign bus.oCPU_RST  = r_cpu_rst;
    assign bus.oCLK_EN   = r_clk_en;
    assign bus.oMode     = r_mode;
    assign bus.oPaused   = r_paused;
    assign bus.oKeyDb    = w_key_db;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_key_step_control.sv
// Directed bench for key_step_control with DEBOUNCE_CYCLES=4, RESET_STRETCH=3;
// per-cycle {oCPU_RST, oCLK_EN} expectations flow through a queue.
module tb_key_step_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [1:0] exp_q[$];

    key_step_control_if bus();

    key_step_control #(
        .DEBOUNCE_CYCLES(4),
        .RESET_STRETCH  (3),
        .CNT_W          (3)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Push n cycles of expected {rst, en}, advance, and compare each on arrival.
    task automatic expect_n(input string tag, input int n, input logic [1:0] e);
        logic [1:0] want;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(e);
            tick();
            want = exp_q.pop_front();
            check(tag, {30'd0, bus.oCPU_RST, bus.oCLK_EN}, {30'd0, want});
        end
    endtask

    task automatic step_press();
        bus.iKEY[1] = 1'b0;
        expect_n("step_wait", 6, 2'b00);
        expect_n("step_pulse", 1, 2'b01);
        bus.iKEY[1] = 1'b1;
        expect_n("step_release", 8, 2'b00);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.iKEY = 4'b1111;
        bus.iSW  = 10'h000;

        // 1. Reset release
        tick();
        tick();
        check("rst_cpu_rst", {31'd0, bus.oCPU_RST}, 32'd1);
        check("rst_clk_en", {31'd0, bus.oCLK_EN}, 32'd0);
        check("rst_mode", {30'd0, bus.oMode}, 32'd0);
        check("rst_paused", {31'd0, bus.oPaused}, 32'd0);
        check("rst_keydb", {28'd0, bus.oKeyDb}, 32'hF);
        rst = 1'b0;
        expect_n("stretch", 3, 2'b10);
        expect_n("run", 5, 2'b01);
        check("run_mode", {30'd0, bus.oMode}, 32'd0);

        // 2. Bounce rejection in STEP
        bus.iSW = 10'h001;
        expect_n("to_step_run", 2, 2'b01);
        expect_n("to_step", 4, 2'b00);
        check("step_mode", {30'd0, bus.oMode}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            bus.iKEY[1] = k[0];
            expect_n("bounce", 2, 2'b00);
        end
        check("bounce_keydb", {28'd0, bus.oKeyDb}, 32'hF);
        bus.iKEY[1] = 1'b0;
        expect_n("bounce_wait", 6, 2'b00);
        expect_n("bounce_pulse", 1, 2'b01);
        expect_n("bounce_after", 3, 2'b00);
        check("bounce_keydb_low", {28'd0, bus.oKeyDb}, 32'hD);
        bus.iKEY[1] = 1'b1;
        expect_n("release_quiet", 10, 2'b00);

        // 3. Divider e=3, then e=0
        bus.iSW = 10'h00E;
        expect_n("div_enter", 10, 2'b00);
        expect_n("div_p1", 1, 2'b01);
        check("div_mode", {30'd0, bus.oMode}, 32'd2);
        expect_n("div_gap1", 7, 2'b00);
        expect_n("div_p2", 1, 2'b01);
        expect_n("div_gap2", 7, 2'b00);
        expect_n("div_p3", 1, 2'b01);
        bus.iSW = 10'h002;
        expect_n("div_e_chg", 3, 2'b00);
        expect_n("div_e0", 5, 2'b01);

        // 4. Pause in RUN
        bus.iSW = 10'h000;
        expect_n("to_run", 6, 2'b01);
        check("run_mode2", {30'd0, bus.oMode}, 32'd0);
        bus.iKEY[2] = 1'b0;
        expect_n("pause_wait", 6, 2'b01);
        expect_n("paused", 1, 2'b00);
        check("paused_flag", {31'd0, bus.oPaused}, 32'd1);
        bus.iKEY[2] = 1'b1;
        expect_n("paused_hold", 8, 2'b00);
        bus.iKEY[1] = 1'b0;
        expect_n("paused_step", 7, 2'b00);
        bus.iKEY[1] = 1'b1;
        expect_n("paused_step_rel", 8, 2'b00);
        check("still_paused", {31'd0, bus.oPaused}, 32'd1);
        bus.iKEY[2] = 1'b0;
        expect_n("resume_wait", 6, 2'b00);
        expect_n("resume", 1, 2'b01);
        check("resumed_flag", {31'd0, bus.oPaused}, 32'd0);
        bus.iKEY[2] = 1'b1;
        expect_n("resume_run", 8, 2'b01);

        // 5. Reset key beats step key in STEP; held reset stretches
        bus.iSW = 10'h001;
        expect_n("to_step2_run", 2, 2'b01);
        expect_n("to_step2", 4, 2'b00);
        bus.iKEY[0] = 1'b0;
        bus.iKEY[1] = 1'b0;
        expect_n("prio_wait", 6, 2'b00);
        expect_n("prio_rst", 4, 2'b10);
        bus.iKEY[0] = 1'b1;
        bus.iKEY[1] = 1'b1;
        expect_n("prio_hold", 9, 2'b10);
        check("prio_keydb", {28'd0, bus.oKeyDb}, 32'hF);
        expect_n("prio_after", 6, 2'b00);
        check("prio_mode", {30'd0, bus.oMode}, 32'd1);

`ifdef KEYCTRL_STEP_COUNT_EN
        // 6. Step counter
        check("cnt_zero", bus.oStepCount, 32'd0);
        for (int s = 0; s < 5; s++) begin
            step_press();
        end
        check("cnt_five", bus.oStepCount, 32'd5);
        bus.iKEY[0] = 1'b0;
        expect_n("cnt_rst_wait", 6, 2'b00);
        expect_n("cnt_rst", 2, 2'b10);
        check("cnt_cleared", bus.oStepCount, 32'd0);
        bus.iKEY[0] = 1'b1;
        expect_n("cnt_rst_hold", 9, 2'b10);
        expect_n("cnt_rst_done", 2, 2'b00);
`else
        step_press();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
